// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared constants for the serial-in / parallel-out shift register:
//   DEFAULT_WIDTH      - default number of register stages
//   DEFAULT_RESET_VAL  - default reset contents (all zeros), sliced to WIDTH
//   WIDTH_MIN/MAX      - legal WIDTH range, enforced at elaboration
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    localparam int WIDTH_MIN     = 2;
    localparam int WIDTH_MAX     = 64;
    localparam int DEFAULT_WIDTH = 4;

    // Held at the widest legal size so any WIDTH can take its low slice.
    localparam logic [WIDTH_MAX-1:0] DEFAULT_RESET_VAL = '0;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_stage.sv
// -----------------------------------------------------------------------------
// shift_reg_stage
// One bit of the shift register: a rising-edge flop with a synchronous,
// active-high reset to a per-stage constant.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active high
//   d_i  - next value of this stage
//   q_o  - registered value of this stage
// -----------------------------------------------------------------------------
module shift_reg_stage #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    // NOTE: rst is only sampled at the clock edge, so it belongs inside the
    // always_ff body and not in the sensitivity list; non-blocking assignment
    // keeps every stage sampling its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : shift_reg_stage

// File: rtl/shift_reg.sv
// -----------------------------------------------------------------------------
// shift_reg
// Serial-in, parallel-out shift register built from WIDTH single-bit stages.
// Every rising edge shifts left: the new bit enters at out[0] and the bit in
// out[WIDTH-1] is dropped. A synchronous reset loads RESET_VAL and wins over
// the serial input on the same edge.
// Parameters:
//   WIDTH      - number of stages, 2..64
//   RESET_VAL  - contents loaded by reset
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous reset, active high
//   in   - serial data input
//   out  - register contents, out[0] newest, out[WIDTH-1] oldest
// -----------------------------------------------------------------------------
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic [WIDTH-1:0] out
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("shift_reg: WIDTH=%0d outside legal range %0d..%0d",
                   WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shift_q;

    // Stage i is fed from stage i-1; stage 0 takes the serial input.
    assign shift_d = {shift_q[WIDTH-2:0], in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        shift_reg_stage #(
            .RESET_VAL (RESET_VAL[i])
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d_i (shift_d[i]),
            .q_o (shift_q[i])
        );
    end

    // Output comes straight from the flops; no path from in to out.
    assign out = shift_q;

endmodule : shift_reg

// File: tb/tb_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_shift_reg
// Drives two shift_reg instances (default 4-bit, and 8-bit with reset value
// 8'hA5). Stimulus is applied on the falling edge and the expected contents
// after the following rising edge are queued; a monitor pops each entry just
// after that rising edge and compares it with the selected instance.
// -----------------------------------------------------------------------------
module tb_shift_reg;

    typedef struct {
        bit         wide;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst4, din4;
    logic       rst8, din8;
    logic [3:0] dout4;
    logic [7:0] dout8;

    exp_t sb[$];
    int   checks;
    int   errors;

    shift_reg u_dut4 (
        .clk (clk),
        .rst (rst4),
        .in  (din4),
        .out (dout4)
    );

    shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .in  (din8),
        .out (dout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one queued expectation per rising edge.
    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = e.wide ? dout8 : {4'b0000, dout4};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    // Apply one cycle of stimulus to the 4-bit instance and queue its result.
    task automatic step4(input bit r, input bit d, input logic [3:0] exp,
                         input string name);
        exp_t e;
        @(negedge clk);
        rst4   = r;
        din4   = d;
        e.wide = 1'b0;
        e.exp  = {4'b0000, exp};
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step8(input bit r, input bit d, input logic [7:0] exp,
                         input string name);
        exp_t e;
        @(negedge clk);
        rst8   = r;
        din8   = d;
        e.wide = 1'b1;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin : stimulus
        logic [3:0] walk4 [5];
        logic [3:0] fill4 [5];
        logic [7:0] walk8 [9];
        logic       pat   [4];
        logic [3:0] pat_e [4];
        logic [3:0] refill[4];

        walk4  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        fill4  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        pat    = '{1'b1, 1'b0, 1'b1, 1'b1};
        pat_e  = '{4'b1111, 4'b1110, 4'b1101, 4'b1011};
        refill = '{4'b1101, 4'b1011, 4'b0111, 4'b1111};
        // A5 shifted by a 1 then seven 0s, then one more 0.
        walk8  = '{8'h4B, 8'h96, 8'h2C, 8'h58, 8'hB0, 8'h60, 8'hC0, 8'h80, 8'h00};

        checks = 0;
        errors = 0;
        rst4   = 1'b1;
        din4   = 1'b0;
        rst8   = 1'b1;
        din8   = 1'b0;

        // Long reset with a toggling input: held at zero on every edge.
        for (int i = 0; i < 13; i++) step4(1'b1, i[0], 4'b0000, "rst_hold");

        // Single 1 walks to the MSB and falls off.
        for (int i = 0; i < 5; i++) step4(1'b0, (i == 0), walk4[i], "walk_one");

        // Continuous 1s fill from the bottom and saturate.
        for (int i = 0; i < 5; i++) step4(1'b0, 1'b1, fill4[i], "fill_ones");

        // Pattern 1,0,1,1 then a 0 pushes the MSB out.
        for (int i = 0; i < 4; i++) step4(1'b0, pat[i], pat_e[i], "pattern");
        step4(1'b0, 1'b0, 4'b0110, "msb_discard");

        // Back to all ones, then a one-cycle reset with in=1 mid-stream.
        for (int i = 0; i < 4; i++) step4(1'b0, 1'b1, refill[i], "refill");
        step4(1'b1, 1'b1, 4'b0000, "rst_dominant");
        step4(1'b0, 1'b1, 4'b0001, "rst_resume");

        // 8-bit instance with non-zero reset value.
        step8(1'b1, 1'b1, 8'hA5, "rst8_load");
        step8(1'b1, 1'b0, 8'hA5, "rst8_hold");
        for (int i = 0; i < 9; i++) step8(1'b0, (i == 0), walk8[i], "walk8");

        // Let the last expectation drain, bounded to a few cycles.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_reg
